// File: rtl/pinwheel_ram_be.sv
// pinwheel_ram_be: single-clock data/code RAM with byte-lane write masks,
// read enable with output hold, write-first forwarding on address collision,
// and an optional zero-fill sequencer that runs after reset.

// One byte lane: a byte-wide array with its own write enable, a registered
// read port, and a registered forwarding capture kept outside the array.
module pinwheel_ram_lane #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wbyte,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  input  logic          fwd,
  output logic [7:0]    rbyte
);
  logic [7:0] mem [DEPTH];
  logic [7:0] dout_q;
  logic [7:0] fwd_byte_q, fwd_byte_d;
  logic       fwd_q, fwd_d;

  // Array write port; plain clocked write so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wbyte;
  end

  // Registered read port with enable: holds its word while re is low.
  always_ff @(posedge clk) begin
    if (re) dout_q <= mem[raddr];
  end

  // Forwarding capture follows the read enable so it holds alongside dout_q.
  always_comb begin
    fwd_d      = fwd_q;
    fwd_byte_d = fwd_byte_q;
    if (re) begin
      fwd_d      = fwd;
      fwd_byte_d = wbyte;
    end
  end

  // Forwarding registers; no reset needed, the top masks rdata until a read.
  always_ff @(posedge clk) begin
    fwd_q      <= fwd_d;
    fwd_byte_q <= fwd_byte_d;
  end

  assign rbyte = fwd_q ? fwd_byte_q : dout_q;
endmodule

module pinwheel_ram_be #(
  parameter int WIDTH          = 32,
  parameter int DEPTH          = 1024,
  parameter bit CLEAR_ON_RESET = 1'b1,
  parameter int AW             = $clog2(DEPTH),
  parameter int NB             = WIDTH / 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [AW-1:0]    raddr,
  input  logic             rden,
  output logic [WIDTH-1:0] rdata,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [NB-1:0]    wmask,
  input  logic             wren,
  output logic             busy
);
  typedef enum logic {S_CLEAR, S_READY} state_e;
  localparam state_e RST_STATE = CLEAR_ON_RESET ? S_CLEAR : S_READY;

  state_e          state_q, state_d;
  logic [AW-1:0]   clr_cnt_q, clr_cnt_d;
  logic            busy_q, busy_d;
  logic            seen_q, seen_d;   // a read has been accepted since reset

  logic            ready, clearing, re, hit;
  logic [NB-1:0]   lane_we, lane_fwd;
  logic [AW-1:0]   lane_waddr;
  logic [NB-1:0][7:0] wdata_b, lane_wbyte, lane_rbyte;

  assign ready    = (state_q == S_READY);
  assign clearing = (state_q == S_CLEAR);
  assign wdata_b  = wdata;
  assign re       = ready & rden;
  assign hit      = re & wren & (raddr == waddr);

  // Clear sequencer: one zero word per cycle, leaves CLEAR after DEPTH-1.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    busy_d    = busy_q;
    seen_d    = seen_q | re;
    if (clearing) begin
      clr_cnt_d = clr_cnt_q + 1'b1;
      if (clr_cnt_q == AW'(DEPTH - 1)) begin
        state_d   = S_READY;
        busy_d    = 1'b0;
        clr_cnt_d = '0;
      end
    end
  end

  // Control state with async reset; busy is registered, never combinational.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RST_STATE;
      clr_cnt_q <= '0;
      busy_q    <= CLEAR_ON_RESET;
      seen_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      busy_q    <= busy_d;
      seen_q    <= seen_d;
    end
  end

  assign lane_waddr = clearing ? clr_cnt_q : waddr;

  // Per-lane controls: the clear writes every lane with zero, otherwise wmask.
  always_comb begin
    for (int i = 0; i < NB; i++) begin
      lane_we[i]    = clearing | (ready & wren & wmask[i]);
      lane_wbyte[i] = clearing ? 8'h00 : wdata_b[i];
      lane_fwd[i]   = hit & wmask[i];
    end
  end

  for (genvar g = 0; g < NB; g++) begin : g_lane
    pinwheel_ram_lane #(.DEPTH(DEPTH), .AW(AW)) u_lane (
      .clk   (clk),
      .we    (lane_we[g]),
      .waddr (lane_waddr),
      .wbyte (lane_wbyte[g]),
      .re    (re),
      .raddr (raddr),
      .fwd   (lane_fwd[g]),
      .rbyte (lane_rbyte[g])
    );
  end

  // Output is zero from reset until the first accepted read.
  assign rdata = seen_q ? lane_rbyte : '0;
  assign busy  = busy_q;
endmodule

// File: tb/tb_pinwheel_ram_be.sv
module tb_pinwheel_ram_be;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A: 32x16, zero-fill on reset
  logic        a_rst_n, a_rden, a_wren, a_busy;
  logic [3:0]  a_raddr, a_waddr, a_wmask;
  logic [31:0] a_wdata, a_rdata;
  // DUT B: 64x8, no zero-fill
  logic        b_rst_n, b_rden, b_wren, b_busy;
  logic [2:0]  b_raddr, b_waddr;
  logic [7:0]  b_wmask;
  logic [63:0] b_wdata, b_rdata;

  pinwheel_ram_be #(.WIDTH(32), .DEPTH(16), .CLEAR_ON_RESET(1'b1)) u_a (
    .clk(clk), .rst_n(a_rst_n), .raddr(a_raddr), .rden(a_rden), .rdata(a_rdata),
    .waddr(a_waddr), .wdata(a_wdata), .wmask(a_wmask), .wren(a_wren), .busy(a_busy));

  pinwheel_ram_be #(.WIDTH(64), .DEPTH(8), .CLEAR_ON_RESET(1'b0)) u_b (
    .clk(clk), .rst_n(b_rst_n), .raddr(b_raddr), .rden(b_rden), .rdata(b_rdata),
    .waddr(b_waddr), .wdata(b_wdata), .wmask(b_wmask), .wren(b_wren), .busy(b_busy));

  int ntests = 0;
  int nfail  = 0;

  // Reference model for DUT A: word array, read register, remaining clear cycles
  logic [31:0] mem_m [16];
  logic [31:0] rd_m;
  int          busy_left;

  typedef struct {
    logic        rden;
    logic [3:0]  raddr;
    logic        wren;
    logic [3:0]  waddr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic [31:0] exp;
  } vec_t;
  vec_t vt [15];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] m);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (m[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  // Model: requests ignored while clearing; otherwise write then read (post-write word).
  task automatic model_edge();
    if (!a_rst_n) begin
      rd_m = '0;
      busy_left = 16;
    end else if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0) for (int i = 0; i < 16; i++) mem_m[i] = '0;
    end else begin
      if (a_wren) mem_m[a_waddr] = merge(mem_m[a_waddr], a_wdata, a_wmask);
      if (a_rden) rd_m = mem_m[a_raddr];
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_edge();
  endtask

  task automatic a_idle();
    a_rden = 1'b0; a_wren = 1'b0; a_raddr = '0; a_waddr = '0; a_wdata = '0; a_wmask = '0;
  endtask

  task automatic a_async_reset(input string nm);
    a_rst_n = 1'b0;
    rd_m = '0;
    busy_left = 16;
    #1;
    chk({nm, "_rdata"}, a_rdata, 64'h0);
    chk({nm, "_busy"}, a_busy, 64'h1);
  endtask

  task automatic count_busy(input string nm);
    int n;
    n = 0;
    while (a_busy && n < 40) begin
      step();
      n++;
    end
    chk(nm, n, 64'd16);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = '{1'b0, 4'd0, 1'b1, 4'd5, 32'hAABBCCDD, 4'hF, 32'h0};
    vt[1]  = '{1'b0, 4'd0, 1'b1, 4'd5, 32'h11223344, 4'h5, 32'h0};
    vt[2]  = '{1'b1, 4'd5, 1'b0, 4'd0, 32'h0,        4'h0, 32'hAA22CC44};
    vt[3]  = '{1'b0, 4'd0, 1'b1, 4'd7, 32'h12345678, 4'hF, 32'hAA22CC44};
    vt[4]  = '{1'b1, 4'd7, 1'b1, 4'd7, 32'hFFFFFFFF, 4'h8, 32'hFF345678};
    vt[5]  = '{1'b1, 4'd7, 1'b0, 4'd0, 32'h0,        4'h0, 32'hFF345678};
    vt[6]  = '{1'b0, 4'd0, 1'b1, 4'd2, 32'hDEADBEEF, 4'hF, 32'hFF345678};
    vt[7]  = '{1'b1, 4'd2, 1'b0, 4'd0, 32'h0,        4'h0, 32'hDEADBEEF};
    vt[8]  = '{1'b0, 4'd1, 1'b1, 4'd2, 32'h11111111, 4'hF, 32'hDEADBEEF};
    vt[9]  = '{1'b0, 4'd3, 1'b1, 4'd2, 32'h22222222, 4'hF, 32'hDEADBEEF};
    vt[10] = '{1'b0, 4'd4, 1'b1, 4'd2, 32'h33333333, 4'hF, 32'hDEADBEEF};
    vt[11] = '{1'b0, 4'd5, 1'b1, 4'd2, 32'h00000000, 4'hF, 32'hDEADBEEF};
    vt[12] = '{1'b1, 4'd2, 1'b0, 4'd0, 32'h0,        4'h0, 32'h00000000};
    vt[13] = '{1'b0, 4'd0, 1'b1, 4'd5, 32'hFFFFFFFF, 4'h0, 32'h00000000};
    vt[14] = '{1'b1, 4'd5, 1'b0, 4'd0, 32'h0,        4'h0, 32'hAA22CC44};

    for (int i = 0; i < 16; i++) mem_m[i] = '0;
    rd_m = '0;
    busy_left = 16;
    a_rst_n = 1'b0; b_rst_n = 1'b0;
    a_idle();
    b_rden = 1'b0; b_wren = 1'b0; b_raddr = '0; b_waddr = '0; b_wdata = '0; b_wmask = '0;
    step(); step();

    // Reset values
    chk("rst_a_rdata", a_rdata, 64'h0);
    chk("rst_a_busy", a_busy, 64'h1);
    chk("rst_b_rdata", b_rdata, 64'h0);
    chk("rst_b_busy", b_busy, 64'h0);

    // DUT B: no clear, ready at once, 64-bit word with masks
    b_rst_n = 1'b1;
    step();
    chk("b_busy_ready", b_busy, 64'h0);
    b_wren = 1'b1; b_waddr = 3'd7; b_wdata = 64'h0123456789ABCDEF; b_wmask = 8'hFF;
    step();
    b_wren = 1'b0; b_rden = 1'b1; b_raddr = 3'd7;
    step();
    chk("b_read7", b_rdata, 64'h0123456789ABCDEF);
    b_rden = 1'b0; b_wren = 1'b1; b_wdata = 64'h0; b_wmask = 8'h0F;
    step();
    b_wren = 1'b0; b_rden = 1'b1;
    step();
    chk("b_read7_mask", b_rdata, 64'h0123456700000000);
    b_rden = 1'b0;

    // DUT A zero-fill with a write and read held on during busy
    a_wren = 1'b1; a_waddr = 4'd3; a_wdata = 32'hFFFFFFFF; a_wmask = 4'hF;
    a_rden = 1'b1; a_raddr = 4'd3;
    a_rst_n = 1'b1;
    count_busy("clear_cycles");
    chk("clear_rdata_held0", a_rdata, 64'h0);
    a_idle();
    for (int i = 0; i < 16; i++) begin
      a_rden = 1'b1; a_raddr = 4'(i);
      step();
      chk($sformatf("zero_rd%0d", i), a_rdata, 64'h0);
    end
    a_idle();

    // Directed vectors: masks, forwarding, read hold, wmask=0
    for (int i = 0; i < 15; i++) begin
      a_rden = vt[i].rden; a_raddr = vt[i].raddr;
      a_wren = vt[i].wren; a_waddr = vt[i].waddr;
      a_wdata = vt[i].wdata; a_wmask = vt[i].wmask;
      step();
      chk($sformatf("vec%0d", i), a_rdata, vt[i].exp);
    end
    a_idle();

    // Random traffic against the model, addresses biased to collide
    for (int i = 0; i < 300; i++) begin
      a_rden  = 1'($urandom_range(0, 1));
      a_wren  = 1'($urandom_range(0, 1));
      a_raddr = (i % 3 == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
      a_waddr = (i % 5 == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
      a_wdata = $urandom;
      a_wmask = 4'($urandom_range(0, 15));
      step();
      chk($sformatf("rand%0d_rdata", i), a_rdata, rd_m);
      chk($sformatf("rand%0d_busy", i), a_busy, 64'(busy_left > 0));
    end
    a_idle();

    // Reset mid-clear
    a_wren = 1'b1; a_waddr = 4'd9; a_wdata = 32'hA5A5A5A5; a_wmask = 4'hF;
    step();
    a_wren = 1'b0; a_rden = 1'b1; a_raddr = 4'd9;
    step();
    chk("pre_reset_read9", a_rdata, 64'hA5A5A5A5);
    a_idle();
    a_async_reset("rst1");
    step();
    a_rst_n = 1'b1;
    for (int i = 0; i < 9; i++) step();
    chk("midclear_busy", a_busy, 64'h1);
    a_async_reset("rst_mid");
    step();
    a_rst_n = 1'b1;
    count_busy("reclear_cycles");
    a_rden = 1'b1; a_raddr = 4'd9;
    step();
    chk("after_reclear_rd9", a_rdata, 64'h0);
    a_raddr = 4'd12;
    step();
    chk("after_reclear_rd12", a_rdata, 64'h0);
    a_idle();

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
